// File: rtl/qspi_storage_arbiter_pkg.sv
// Shared types and defaults for the QSPI storage arbiter: FSM states, default
// widths and the programming-port index.
package qspi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int DEF_N_REQ       = 3;
    localparam int DEF_ADDR_W      = 24;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_TIMEOUT_CYC = 4096;
    localparam int BE_W            = 4;

    // The programming loader always occupies the highest port index.
    function automatic int prog_port(input int n_req);
        return n_req - 1;
    endfunction

endpackage

// File: rtl/qspi_storage_arbiter_rr_picker.sv
// Combinational round-robin search: first set bit of the eligible mask at or
// after rr_ptr, wrapping around.
module rr_picker #(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] eligible,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin : search
        int                 pos;
        logic [IDX_W-1:0]   cand;
        idx   = '0;
        valid = 1'b0;
        pos   = 0;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pos = int'(rr_ptr) + i;
            if (pos >= N_REQ) pos = pos - N_REQ;
            cand = pos[IDX_W-1:0];
            if (!valid && eligible[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/qspi_storage_arbiter.sv
// Round-robin arbiter sharing one QSPI storage controller between requesters,
// with programming-mode gating and a transaction timeout that aborts the controller.
module qspi_storage_arbiter
    import qspi_arb_pkg::*;
#(
    parameter int N_REQ       = DEF_N_REQ,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   prog_mode,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       req_we,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    input  logic [N_REQ*BE_W-1:0]  req_be,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       rvalid,
    output logic                   rerr,
    output logic [DATA_W-1:0]      rdata,
    output logic                   ctrl_req,
    output logic                   ctrl_we,
    output logic [ADDR_W-1:0]      ctrl_addr,
    output logic [DATA_W-1:0]      ctrl_wdata,
    output logic [BE_W-1:0]        ctrl_be,
    input  logic                   ctrl_ready,
    input  logic                   ctrl_done,
    input  logic [DATA_W-1:0]      ctrl_rdata,
    output logic                   ctrl_abort,
    output logic                   busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [N_REQ-1:0] PROG_MASK = N_REQ'(1) << prog_port(N_REQ);

    arb_state_t        state, next_state;
    logic [N_REQ-1:0]  eligible;
    logic [IDX_W-1:0]  pick_idx, rr_ptr, idx_lat;
    logic              pick_vld;
    logic [CNT_W-1:0]  cnt;
    logic              timeout;

    assign eligible = prog_mode ? (req & PROG_MASK) : req;
    assign timeout  = (cnt == CNT_LAST);

    rr_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_picker (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .idx      (pick_idx),
        .valid    (pick_vld)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Acceptance by the controller outranks a timeout in ISSUE; a completion
    // outranks a timeout in the same cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pick_vld) next_state = ISSUE;
            ISSUE:   if (ctrl_ready && ctrl_done) next_state = RESP;
                     else if (ctrl_ready)         next_state = WAIT;
                     else if (timeout)            next_state = RESP;
            WAIT:    if (ctrl_done || timeout) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        gnt        = '0;
        rvalid     = '0;
        ctrl_req   = (state == ISSUE);
        ctrl_abort = timeout && (((state == ISSUE) && !ctrl_ready) ||
                                 ((state == WAIT) && !ctrl_done));
        busy       = (state != IDLE);
        if (state == IDLE && pick_vld && !rst) gnt = N_REQ'(1) << pick_idx;
        if (state == RESP)                     rvalid = N_REQ'(1) << idx_lat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= '0;
            idx_lat    <= '0;
            ctrl_we    <= 1'b0;
            ctrl_addr  <= '0;
            ctrl_wdata <= '0;
            ctrl_be    <= '0;
            cnt        <= '0;
            rdata      <= '0;
            rerr       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (pick_vld) begin
                        idx_lat    <= pick_idx;
                        ctrl_we    <= req_we[pick_idx];
                        ctrl_addr  <= req_addr[pick_idx*ADDR_W +: ADDR_W];
                        ctrl_wdata <= req_wdata[pick_idx*DATA_W +: DATA_W];
                        ctrl_be    <= req_be[pick_idx*BE_W +: BE_W];
                        rr_ptr     <= (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
                    end
                end
                ISSUE: begin
                    if (ctrl_ready && ctrl_done) begin
                        rdata <= ctrl_we ? '0 : ctrl_rdata;
                        rerr  <= 1'b0;
                    end else if (ctrl_ready) begin
                        cnt <= '0;
                    end else if (timeout) begin
                        rdata <= '0;
                        rerr  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (ctrl_done) begin
                        rdata <= ctrl_we ? '0 : ctrl_rdata;
                        rerr  <= 1'b0;
                    end else if (timeout) begin
                        rdata <= '0;
                        rerr  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_qspi_storage_arbiter.sv
// Directed bench for qspi_storage_arbiter: single read, round-robin order,
// programming mode, write path, same-cycle completion, timeout and reset.
module tb_qspi_storage_arbiter;

    localparam int N  = 3;
    localparam int AW = 24;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          prog_mode;
    logic [N-1:0]  req;
    logic          a_we    [N];
    logic [AW-1:0] a_addr  [N];
    logic [DW-1:0] a_wdata [N];
    logic [3:0]    a_be    [N];
    logic [N-1:0]    req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N*4-1:0]  req_be;
    logic [N-1:0]  gnt, rvalid;
    logic          rerr, ctrl_req, ctrl_we, ctrl_abort, busy;
    logic [DW-1:0] rdata, ctrl_wdata, ctrl_rdata;
    logic [AW-1:0] ctrl_addr;
    logic [3:0]    ctrl_be;
    logic          ctrl_ready, ctrl_done;

    int n_checks = 0;
    int n_errors = 0;

    assign req_we    = {a_we[2], a_we[1], a_we[0]};
    assign req_addr  = {a_addr[2], a_addr[1], a_addr[0]};
    assign req_wdata = {a_wdata[2], a_wdata[1], a_wdata[0]};
    assign req_be    = {a_be[2], a_be[1], a_be[0]};

    always #5 clk = ~clk;

    qspi_storage_arbiter #(
        .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst), .prog_mode(prog_mode),
        .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be),
        .gnt(gnt), .rvalid(rvalid), .rerr(rerr), .rdata(rdata),
        .ctrl_req(ctrl_req), .ctrl_we(ctrl_we), .ctrl_addr(ctrl_addr),
        .ctrl_wdata(ctrl_wdata), .ctrl_be(ctrl_be),
        .ctrl_ready(ctrl_ready), .ctrl_done(ctrl_done), .ctrl_rdata(ctrl_rdata),
        .ctrl_abort(ctrl_abort), .busy(busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge in IDLE with req already driven; returns at the
    // falling edge after the response, back in IDLE.
    task automatic txn(input int p, input logic [31:0] rd, input int done_wait);
        logic [31:0] exp_rd;
        exp_rd = a_we[p] ? 32'h0 : rd;
        #1;
        check_eq("gnt", gnt, 64'(1) << p);
        @(negedge clk); #1;
        check_eq("ctrl_req", ctrl_req, 1);
        check_eq("ctrl_we", ctrl_we, a_we[p]);
        check_eq("ctrl_addr", ctrl_addr, a_addr[p]);
        check_eq("ctrl_wdata", ctrl_wdata, a_wdata[p]);
        check_eq("ctrl_be", ctrl_be, a_be[p]);
        check_eq("busy", busy, 1);
        check_eq("gnt_issue", gnt, 0);
        ctrl_ready = 1'b1;
        @(negedge clk);
        ctrl_ready = 1'b0;
        #1;
        check_eq("ctrl_req_wait", ctrl_req, 0);
        repeat (done_wait) @(negedge clk);
        ctrl_done  = 1'b1;
        ctrl_rdata = rd;
        @(negedge clk);
        ctrl_done  = 1'b0;
        ctrl_rdata = 32'h5555_5555;
        #1;
        check_eq("rvalid", rvalid, 64'(1) << p);
        check_eq("rdata", rdata, exp_rd);
        check_eq("rerr", rerr, 0);
        check_eq("gnt_resp", gnt, 0);
        @(negedge clk);
    endtask

    initial begin
        int abort_cnt, abort_at, rv_at;
        logic [N-1:0]  rv_seen;
        logic          rerr_seen;
        logic [DW-1:0] rd_seen;

        rst = 1'b1; prog_mode = 1'b0; req = '0;
        ctrl_ready = 1'b0; ctrl_done = 1'b0; ctrl_rdata = '0;
        a_addr[0] = 24'h000100; a_addr[1] = 24'h000040; a_addr[2] = 24'h00F000;
        a_wdata[0] = 32'h0000_0011; a_wdata[1] = 32'h0000_0022; a_wdata[2] = 32'h0000_0033;
        for (int i = 0; i < N; i++) begin
            a_we[i] = 1'b0;
            a_be[i] = 4'hF;
        end

        @(negedge clk); #1;
        check_eq("rst_gnt", gnt, 0);
        check_eq("rst_rvalid", rvalid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ctrl_req", ctrl_req, 0);
        check_eq("rst_abort", ctrl_abort, 0);
        check_eq("rst_rdata", rdata, 0);
        check_eq("rst_rerr", rerr, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single read on port 0, completion 5 cycles after acceptance
        req = 3'b001;
        txn(0, 32'hDEAD_BEEF, 4);
        req = '0;

        // Reset pulse restarts round-robin at port 0 and clears rdata
        rst = 1'b1; #1;
        check_eq("pulse_rdata", rdata, 0);
        check_eq("pulse_rvalid", rvalid, 0);
        @(negedge clk);
        rst = 1'b0;

        req = 3'b111;
        for (int k = 0; k < 6; k++) txn(k % 3, 32'h1000_0000 + k, 0);

        prog_mode = 1'b1;
        txn(2, 32'h2222_0001, 0);
        txn(2, 32'h2222_0002, 1);
        prog_mode = 1'b0;
        txn(0, 32'h3333_0000, 0);
        txn(1, 32'h3333_0001, 0);

        req = '0; #1;
        check_eq("idle_nogrant", gnt, 0);
        @(negedge clk); #1;
        check_eq("idle_busy", busy, 0);
        @(negedge clk);

        // Write through port 1
        a_we[1] = 1'b1; a_addr[1] = 24'h000040; a_wdata[1] = 32'h1234_5678; a_be[1] = 4'b0011;
        req = 3'b010;
        txn(1, 32'hFFFF_FFFF, 1);
        a_we[1] = 1'b0;

        // Acceptance and completion in the same ISSUE cycle skip WAIT
        req = 3'b100; #1;
        check_eq("same_gnt", gnt, 3'b100);
        @(negedge clk); #1;
        check_eq("same_ctrl_req", ctrl_req, 1);
        ctrl_ready = 1'b1; ctrl_done = 1'b1; ctrl_rdata = 32'hA5A5_0F0F; req = '0;
        @(negedge clk);
        ctrl_ready = 1'b0; ctrl_done = 1'b0; #1;
        check_eq("same_rvalid", rvalid, 3'b100);
        check_eq("same_rdata", rdata, 32'hA5A5_0F0F);
        check_eq("same_rerr", rerr, 0);
        @(negedge clk);

        // Completion never arrives: abort on the 16th WAIT cycle
        req = 3'b010; #1;
        check_eq("to_gnt", gnt, 3'b010);
        @(negedge clk);
        ctrl_ready = 1'b1;
        @(negedge clk);
        ctrl_ready = 1'b0; req = '0;
        abort_cnt = 0; abort_at = -1; rv_at = -1;
        rv_seen = '0; rerr_seen = 1'b0; rd_seen = 32'hFFFF_FFFF;
        for (int i = 0; i < 40 && rv_at < 0; i++) begin
            #1;
            if (ctrl_abort) begin
                abort_cnt++;
                if (abort_at < 0) abort_at = i;
            end
            if (rvalid != '0) begin
                rv_at = i; rv_seen = rvalid; rerr_seen = rerr; rd_seen = rdata;
            end
            @(negedge clk);
        end
        check_eq("to_abort_cnt", abort_cnt, 1);
        check_eq("to_abort_at", abort_at, 15);
        check_eq("to_rvalid_at", rv_at, 16);
        check_eq("to_rvalid", rv_seen, 3'b010);
        check_eq("to_rerr", rerr_seen, 1);
        check_eq("to_rdata", rd_seen, 0);
        #1;
        check_eq("to_idle", busy, 0);
        @(negedge clk);

        // Reset in WAIT drops the transaction and rewinds round-robin
        req = 3'b010; #1;
        check_eq("rw_gnt", gnt, 3'b010);
        @(negedge clk);
        ctrl_ready = 1'b1;
        @(negedge clk);
        ctrl_ready = 1'b0; req = '0;
        @(negedge clk);
        rst = 1'b1; #1;
        check_eq("rw_busy", busy, 0);
        check_eq("rw_ctrl_req", ctrl_req, 0);
        check_eq("rw_ctrl_addr", ctrl_addr, 0);
        check_eq("rw_abort", ctrl_abort, 0);
        ctrl_done = 1'b1; ctrl_rdata = 32'h7777_7777;
        @(negedge clk);
        ctrl_done = 1'b0; #1;
        check_eq("rw_no_rvalid", rvalid, 0);
        check_eq("rw_rdata", rdata, 0);
        @(negedge clk);
        rst = 1'b0;
        req = 3'b111;
        txn(0, 32'hCAFE_F00D, 0);
        req = '0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
